// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared constants and types for the VGA timing generator.
// Holds the 800x600@72Hz default timing, the derived line/frame totals and
// sync windows, and the colour-bar table used when VGA_TEST_PATTERN_EN is set.
package vga_timing_pkg;

    // Counter width and the largest total it can represent.
    localparam int CNT_W   = 11;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // 800x600@72Hz at a 50 MHz pixel rate.
    localparam int DEF_H_VIS  = 800;
    localparam int DEF_H_FP   = 56;
    localparam int DEF_H_SYNC = 120;
    localparam int DEF_H_BP   = 64;
    localparam int DEF_V_VIS  = 600;
    localparam int DEF_V_FP   = 37;
    localparam int DEF_V_SYNC = 6;
    localparam int DEF_V_BP   = 23;

    localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 1040
    localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 666

    // Inclusive sync windows: HSync 856..975, VSync 637..642.
    localparam int DEF_HS_START = DEF_H_VIS + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
    localparam int DEF_VS_START = DEF_V_VIS + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

    // Test pattern: eight 100-pixel vertical bars; entry 0 is the leftmost bar.
    localparam int BAR_W = 100;
    localparam rgb_t [7:0] TEST_BAR_COLOURS = {
        12'hFFF, 12'hFF0, 12'hF0F, 12'hF00,
        12'h0FF, 12'h0F0, 12'h00F, 12'h000
    };

    // Bar number for a visible column (only 0..7 occur on visible pixels).
    function automatic logic [2:0] bar_index(input cnt_t x);
        return 3'(x / cnt_t'(BAR_W));
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: divides the 100 MHz clock by two to give the pixel enable.
// PixelTick is the divider bit itself, so it is high on every other CLK and
// the first tick is consumed by the 2nd CLK edge after reset release.
module vga_pix_div (
    input  logic CLK_100MHz,
    input  logic RESET_N,
    output logic PixelTick
);

    logic div;

    // Toggle the divider every clock; cleared while reset is held.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            div <= 1'b0;
        end else begin
            div <= ~div;
        end
    end

    assign PixelTick = div;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with a one-pixel registered output stage.
// Counters, blanking/sync decode and the colour/sync output registers live
// here; the pixel enable comes from vga_pix_div.
// Optional feature: define VGA_TEST_PATTERN_EN to add the TEST_PAT input and
// an eight-bar colour test pattern that overrides the client colour.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP
) (
    input  logic        CLK_100MHz,
    input  logic        RESET_N,
    input  logic [3:0]  RED_IN,
    input  logic [3:0]  GREEN_IN,
    input  logic [3:0]  BLUE_IN,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        TEST_PAT,
`endif
    output logic [10:0] CurrentX,
    output logic [10:0] CurrentY,
    output logic        HBlank,
    output logic        VBlank,
    output logic        PixelTick,
    output logic        FrameStart,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Totals that do not fit the 11-bit counters stop elaboration.
    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_timing
        $error("vga_timing_gen: H_TOTAL=%0d or V_TOTAL=%0d exceeds %0d", H_TOTAL, V_TOTAL, CNT_MAX);
    end

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS_C  = cnt_t'(H_VIS);
    localparam cnt_t V_VIS_C  = cnt_t'(V_VIS);
    localparam cnt_t HS_START = cnt_t'(H_VIS + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_VIS + H_FP + H_SYNC - 1);
    localparam cnt_t VS_START = cnt_t'(V_VIS + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_VIS + V_FP + V_SYNC - 1);

    logic raw_hs;
    logic raw_vs;
    rgb_t pix_rgb;
    rgb_t out_rgb;

    vga_pix_div u_pix_div (
        .CLK_100MHz (CLK_100MHz),
        .RESET_N    (RESET_N),
        .PixelTick  (PixelTick)
    );

    // Raster counters: X advances every pixel, Y advances when X wraps.
    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            CurrentX <= '0;
            CurrentY <= '0;
        end else if (PixelTick) begin
            if (CurrentX == H_LAST) begin
                CurrentX <= '0;
                CurrentY <= (CurrentY == V_LAST) ? '0 : CurrentY + 1'b1;
            end else begin
                CurrentX <= CurrentX + 1'b1;
            end
        end
    end

    // Decode blanking, sync, frame start and the colour for the current pixel.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        HBlank     = (CurrentX >= H_VIS_C);
        VBlank     = (CurrentY >= V_VIS_C);
        raw_hs     = (CurrentX >= HS_START) && (CurrentX <= HS_END);
        raw_vs     = (CurrentY >= VS_START) && (CurrentY <= VS_END);
        FrameStart = PixelTick && (CurrentX == H_LAST) && (CurrentY == V_LAST);
        pix_rgb    = {RED_IN, GREEN_IN, BLUE_IN};
`ifdef VGA_TEST_PATTERN_EN
        if (TEST_PAT) begin
            pix_rgb = TEST_BAR_COLOURS[bar_index(CurrentX)];
        end
`endif
    end

    // Output stage: colour and sync registered together on each pixel tick.
    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            out_rgb <= '0;
            VGA_HS  <= 1'b0;
            VGA_VS  <= 1'b0;
        end else if (PixelTick) begin
            out_rgb <= (HBlank || VBlank) ? '0 : pix_rgb;
            VGA_HS  <= raw_hs;
            VGA_VS  <= raw_vs;
        end
    end

    assign VGA_R = out_rgb.r;
    assign VGA_G = out_rgb.g;
    assign VGA_B = out_rgb.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// The stimulus process queues expected values keyed by (reset phase, pixel
// tick); the monitor samples on the falling edge and compares whenever the
// DUT presents a pixel tick (or is held in reset). A second instance with a
// tiny raster covers frame-level behaviour in a few hundred clocks.
module tb_vga_timing_gen;

    typedef struct {
        int    phase;
        int    tick;
        string sig;
        int    exp;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] red, green, blue;
    logic       test_pat;

    // Full-size instance
    logic [10:0] CurrentX, CurrentY;
    logic        HBlank, VBlank, PixelTick, FrameStart;
    logic [3:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS;

    // Small instance: H 8/2/3/2 (total 15), V 6/2/2/1 (total 11)
    logic [10:0] s_x, s_y;
    logic        s_hb, s_vb, s_tick, s_fs;
    logic [3:0]  s_r, s_g, s_b;
    logic        s_hs, s_vs;

    vga_timing_gen dut (
        .CLK_100MHz (clk),
        .RESET_N    (rst_n),
        .RED_IN     (red),
        .GREEN_IN   (green),
        .BLUE_IN    (blue),
`ifdef VGA_TEST_PATTERN_EN
        .TEST_PAT   (test_pat),
`endif
        .CurrentX   (CurrentX),
        .CurrentY   (CurrentY),
        .HBlank     (HBlank),
        .VBlank     (VBlank),
        .PixelTick  (PixelTick),
        .FrameStart (FrameStart),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS)
    );

    vga_timing_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(1)
    ) dut_small (
        .CLK_100MHz (clk),
        .RESET_N    (rst_n),
        .RED_IN     (red),
        .GREEN_IN   (green),
        .BLUE_IN    (blue),
`ifdef VGA_TEST_PATTERN_EN
        .TEST_PAT   (1'b0),
`endif
        .CurrentX   (s_x),
        .CurrentY   (s_y),
        .HBlank     (s_hb),
        .VBlank     (s_vb),
        .PixelTick  (s_tick),
        .FrameStart (s_fs),
        .VGA_R      (s_r),
        .VGA_G      (s_g),
        .VGA_B      (s_b),
        .VGA_HS     (s_hs),
        .VGA_VS     (s_vs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running clock count and the count at the last reset release.
    int cyc = 0;
    int rel_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge rst_n) rel_cyc <= cyc;

    // Scoreboard queue: written only by the stimulus process.
    exp_t exp_q[$];
    logic end_req = 1'b0;
    logic aborted = 1'b0;

    // Monitor-owned state
    bit   done_flags[1024];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   phase    = 0;
    logic in_reset = 1'b1;
    int   tick_idx = 0;
    int   tick_clk = 0;
    int   line_period = 0, last_x0 = 0;
    bit   have_x0 = 0;
    int   s_frame_period = 0, last_fs = 0;
    bit   have_fs = 0;
    int   hs_ticks = 0, s_vs_ticks = 0;

    function automatic int actual(input string sig);
        case (sig)
            "x":              return int'(CurrentX);
            "y":              return int'(CurrentY);
            "hblank":         return int'(HBlank);
            "vblank":         return int'(VBlank);
            "tick":           return int'(PixelTick);
            "fs":             return int'(FrameStart);
            "rgb":            return int'({VGA_R, VGA_G, VGA_B});
            "hs":             return int'(VGA_HS);
            "vs":             return int'(VGA_VS);
            "s_x":            return int'(s_x);
            "s_y":            return int'(s_y);
            "s_hblank":       return int'(s_hb);
            "s_vblank":       return int'(s_vb);
            "s_fs":           return int'(s_fs);
            "s_hs":           return int'(s_hs);
            "s_vs":           return int'(s_vs);
            "s_rgb":          return int'({s_r, s_g, s_b});
            "tick_clk":       return tick_clk;
            "line_period":    return line_period;
            "hs_ticks":       return hs_ticks;
            "s_frame_period": return s_frame_period;
            "s_vs_ticks":     return s_vs_ticks;
            default:          return -1;
        endcase
    endfunction

    // Compare every queued expectation that belongs to this sample point.
    task automatic scan(input int cur);
        int act;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (!done_flags[i] && exp_q[i].phase == phase && exp_q[i].tick == cur) begin
                done_flags[i] = 1'b1;
                n_checks++;
                act = actual(exp_q[i].sig);
                if (act != exp_q[i].exp) begin
                    n_fail++;
                    $display("FAIL %s (phase %0d tick %0d): got 0x%0h, expected 0x%0h",
                             exp_q[i].sig, phase, cur, act, exp_q[i].exp);
                end
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (end_req) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (!done_flags[i]) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL %s (phase %0d tick %0d): never observed, expected 0x%0h",
                                 exp_q[i].sig, exp_q[i].phase, exp_q[i].tick, exp_q[i].exp);
                    end
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
            if (!rst_n) begin
                in_reset = 1'b1;
                scan(-1);
            end else begin
                if (in_reset) begin
                    in_reset = 1'b0;
                    phase++;
                    tick_idx = 0;
                    have_x0 = 0; have_fs = 0;
                    line_period = 0; s_frame_period = 0;
                    hs_ticks = 0; s_vs_ticks = 0;
                end
                if (PixelTick) begin
                    tick_clk = cyc - rel_cyc;
                    if (CurrentX == 11'd0) begin
                        if (have_x0) line_period = cyc - last_x0;
                        last_x0 = cyc;
                        have_x0 = 1;
                    end
                    if (s_fs) begin
                        if (have_fs) s_frame_period = cyc - last_fs;
                        last_fs = cyc;
                        have_fs = 1;
                    end
                    scan(tick_idx);
                    if (VGA_HS) hs_ticks++;
                    if (s_vs) s_vs_ticks++;
                    tick_idx++;
                end
            end
        end
    end

    task automatic expect_at(input int p, input int t, input string sig, input int v);
        exp_t e;
        e.phase = p; e.tick = t; e.sig = sig; e.exp = v;
        exp_q.push_back(e);
    endtask

    // Expected values while reset is held: everything reads 0.
    task automatic expect_reset(input int p);
        expect_at(p, -1, "x", 0);      expect_at(p, -1, "y", 0);
        expect_at(p, -1, "hblank", 0); expect_at(p, -1, "vblank", 0);
        expect_at(p, -1, "tick", 0);   expect_at(p, -1, "fs", 0);
        expect_at(p, -1, "rgb", 0);    expect_at(p, -1, "hs", 0);
        expect_at(p, -1, "vs", 0);     expect_at(p, -1, "s_x", 0);
        expect_at(p, -1, "s_y", 0);    expect_at(p, -1, "s_vblank", 0);
        expect_at(p, -1, "s_vs", 0);
    endtask

    // Wait until the monitor has sampled tick t of phase p (bounded).
    task automatic wait_tick(input int p, input int t);
        int n;
        n = 0;
        while (!aborted && !(phase == p && !in_reset && tick_idx > t)) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 10000) begin
                aborted = 1'b1;
                expect_at(-9, t, "timeout_wait", 1);
            end
        end
    endtask

    task automatic set_rgb(input logic [11:0] c);
        {red, green, blue} = c;
    endtask

    // Stimulus
    initial begin
        rst_n    = 1'b0;
        test_pat = 1'b0;
        set_rgb(12'hFA5);
        expect_reset(0);
        repeat (3) @(negedge clk);

        // Phase 1: full-size line checks, small-raster frame checks.
        expect_at(1, 0, "x", 0);         expect_at(1, 0, "y", 0);
        expect_at(1, 0, "hblank", 0);    expect_at(1, 0, "vblank", 0);
        expect_at(1, 0, "fs", 0);        expect_at(1, 0, "rgb", 12'h000);
        expect_at(1, 0, "tick_clk", 1);  expect_at(1, 1, "tick_clk", 3);
        expect_at(1, 2, "tick_clk", 5);  expect_at(1, 1, "x", 1);
        expect_at(1, 1, "rgb", 12'hFA5); expect_at(1, 200, "rgb", 12'hFA5);
        expect_at(1, 201, "rgb", 12'h3C7);
        expect_at(1, 301, "rgb", 12'h3C7); expect_at(1, 302, "rgb", 12'h3C7);
        expect_at(1, 799, "x", 799);     expect_at(1, 799, "hblank", 0);
        expect_at(1, 800, "hblank", 1);  expect_at(1, 800, "rgb", 12'h3C7);
        expect_at(1, 801, "rgb", 12'h000);
        expect_at(1, 856, "hs", 0);      expect_at(1, 857, "hs", 1);
        expect_at(1, 976, "hs", 1);      expect_at(1, 977, "hs", 0);
        expect_at(1, 1039, "x", 1039);   expect_at(1, 1039, "y", 0);
        expect_at(1, 1040, "x", 0);      expect_at(1, 1040, "y", 1);
        expect_at(1, 1040, "line_period", 2080);
        expect_at(1, 1040, "hs_ticks", 120);
        expect_at(1, 1040, "fs", 0);
        // Small raster: X = t mod 15, Y = (t / 15) mod 11
        expect_at(1, 14, "s_x", 14);     expect_at(1, 15, "s_x", 0);
        expect_at(1, 15, "s_y", 1);
        expect_at(1, 7, "s_hblank", 0);  expect_at(1, 8, "s_hblank", 1);
        expect_at(1, 8, "s_rgb", 12'hFA5); expect_at(1, 9, "s_rgb", 12'h000);
        expect_at(1, 10, "s_hs", 0);     expect_at(1, 11, "s_hs", 1);
        expect_at(1, 13, "s_hs", 1);     expect_at(1, 14, "s_hs", 0);
        expect_at(1, 89, "s_vblank", 0); expect_at(1, 90, "s_vblank", 1);
        expect_at(1, 91, "s_rgb", 12'h000);
        expect_at(1, 164, "s_vblank", 1); expect_at(1, 165, "s_vblank", 0);
        expect_at(1, 120, "s_vs", 0);    expect_at(1, 121, "s_vs", 1);
        expect_at(1, 150, "s_vs", 1);    expect_at(1, 151, "s_vs", 0);
        expect_at(1, 163, "s_fs", 0);    expect_at(1, 164, "s_fs", 1);
        expect_at(1, 165, "s_fs", 0);    expect_at(1, 329, "s_fs", 1);
        expect_at(1, 329, "s_frame_period", 330);
        expect_at(1, 165, "s_vs_ticks", 30);
        #1 rst_n = 1'b1;

        // New client colour takes effect on the next pixel.
        wait_tick(1, 200);
        set_rgb(12'h3C7);

        // Garbage driven only between ticks must never reach the outputs.
        wait_tick(1, 300);
        @(negedge clk); #1 set_rgb(12'h000);
        @(negedge clk); #1 set_rgb(12'h3C7);

        // Mid-frame asynchronous reset at X=402, Y=1 (small raster in VSync).
        wait_tick(1, 1441);
        expect_reset(1);
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Phase 2: fresh frame from (0,0), no FrameStart for the aborted one.
        expect_at(2, 0, "x", 0);        expect_at(2, 0, "y", 0);
        expect_at(2, 0, "fs", 0);       expect_at(2, 0, "rgb", 12'h000);
        expect_at(2, 0, "s_x", 0);      expect_at(2, 0, "s_y", 0);
        expect_at(2, 0, "s_fs", 0);     expect_at(2, 0, "tick_clk", 1);
        expect_at(2, 1, "x", 1);        expect_at(2, 1, "tick_clk", 3);
`ifdef VGA_TEST_PATTERN_EN
        test_pat = 1'b1;
        expect_at(2, 1, "rgb", 12'h000);
        expect_at(2, 201, "rgb", 12'h0F0); expect_at(2, 300, "rgb", 12'h0F0);
        expect_at(2, 301, "rgb", 12'h0FF); expect_at(2, 701, "rgb", 12'hFFF);
        expect_at(2, 800, "rgb", 12'hFFF); expect_at(2, 801, "rgb", 12'h000);
        expect_at(2, 1041, "rgb", 12'h3C7);
        #1 rst_n = 1'b1;
        wait_tick(2, 900);
        test_pat = 1'b0;
        wait_tick(2, 1042);
`else
        expect_at(2, 1, "rgb", 12'h3C7); expect_at(2, 2, "rgb", 12'h3C7);
        #1 rst_n = 1'b1;
        wait_tick(2, 5);
`endif

        repeat (2) @(negedge clk);
        #1 end_req = 1'b1;
        repeat (20) @(negedge clk);
        $display("FAIL monitor: summary not reached");
        $fatal(1);
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be as follows:
- H_VIS, 800, visible pixels per line.
- H_FP, 56, horizontal front porch.
- H_SYNC, 120, HSync width.
- H_BP, 64, horizontal back porch.
- V_VIS, 600, visible lines.
- V_FP, 37, vertical front porch.
- V_SYNC, 6, VSync width.
- V_BP, 23, vertical back porch.
- This is 800x600@72Hz at a 50 MHz pixel rate.
REQ-002 Ports SHALL be as follows, clock and reset first:
- CLK_100MHz  in  1  sole clock.
- RESET_N  in  1  asynchronous active-low reset.
- RED_IN/GREEN_IN/BLUE_IN  in  4 each  colour from the client for the current (CurrentX, CurrentY).
- CurrentX  out  11  horizontal pixel counter.
- CurrentY  out  11  vertical line counter.
- HBlank  out  1  CurrentX >= H_VIS.
- VBlank  out  1  CurrentY >= V_VIS.
- PixelTick  out  1  one-CLK pulse on every pixel period.
- FrameStart  out  1  one-CLK pulse when the counters wrap to (0,0).
- VGA_R/VGA_G/VGA_B  out  4 each  registered DAC colour.
- VGA_HS/VGA_VS  out  1 each  sync outputs, active high.
REQ-003 The block SHALL use one clock, CLK_100MHz, and an asynchronous active-low reset, RESET_N; no other clock or reset SHALL exist.

Function
REQ-004 A 1-bit divider SHALL toggle every CLK; PixelTick SHALL be high when the divider is 1, giving a 50% duty 50 MHz pixel rate. The first PixelTick SHALL occur on the 2nd CLK edge after reset release.
REQ-005 CurrentX SHALL increment on each PixelTick and wrap from H_TOTAL-1 (1039) to 0.
REQ-006 CurrentY SHALL increment only on a PixelTick where CurrentX wraps, and SHALL wrap from V_TOTAL-1 (665) to 0.
REQ-007 HBlank and VBlank SHALL be decoded from the registered counters with no added delay.
REQ-008 Sync SHALL be decoded from the counters:
- raw HSync is high for CurrentX in [856, 975];
- raw VSync is high for CurrentY in [637, 642].
REQ-009 Output pipeline:
- On each PixelTick, VGA_R/G/B SHALL register {RED_IN,GREEN_IN,BLUE_IN}, forced to 0 when HBlank or VBlank is high.
- VGA_HS and VGA_VS SHALL register the raw syncs on the same tick, so colour and sync stay aligned with 1-pixel latency.
REQ-010 FrameStart SHALL pulse for exactly one CLK, coincident with the PixelTick on which both counters wrap from (1039, 665) to (0, 0).
REQ-011 Between PixelTicks, every output register SHALL hold its value; client inputs SHALL be sampled only on PixelTick.
REQ-012 Counter widths SHALL be 11 bits; H_TOTAL and V_TOTAL SHALL be computed parameter sums, and any sum that exceeds 2047 SHALL be an elaboration error.

Reset
REQ-013 While RESET_N is low, all of the following SHALL be 0: divider, CurrentX, CurrentY, HBlank, VBlank, PixelTick, FrameStart, VGA_R/G/B, VGA_HS, VGA_VS.
REQ-014 Reset asserted mid-frame SHALL clear state immediately (asynchronously); after release, the timing SHALL restart at (0, 0) as a fresh frame, with no FrameStart pulse for the aborted frame.

Configuration
REQ-015 Macro VGA_TEST_PATTERN_EN:
- When defined, an extra input TEST_PAT (1 bit) SHALL exist. With TEST_PAT=1, the registered colour SHALL be 8 vertical bars of width 100 px, colours in order 000, 00F, 0F0, 0FF, F00, F0F, FF0, FFF (bar = CurrentX/100), and the client inputs SHALL be ignored. With TEST_PAT=0, behaviour SHALL match the undefined case.
- When undefined, the TEST_PAT port and the bar logic SHALL be absent.

Structure
REQ-016 Package vga_timing_pkg SHALL hold the 800x600@72 default timing constants, the computed H_TOTAL/V_TOTAL, the sync start/end constants, and the test-pattern colour table.
REQ-017 Sub-module vga_pix_div SHALL implement the divider and PixelTick; counters, decode and output registers SHALL reside in vga_timing_gen.

Verification
REQ-018 Release reset with 400 CLK of free-run -> PixelTick pulses at CLK 2, 4, 6, ...; CurrentX reaches 1 on the first tick.
REQ-019 Run one full line -> HBlank rises when CurrentX becomes 800. VGA_HS is high for exactly 120 ticks, starting one tick after CurrentX = 856. Line period is 2080 CLK.
REQ-020 Run one full frame -> FrameStart pulses once every 1,385,280 CLK. VBlank is high for lines 600-665. VGA_VS is high for 6 lines.
REQ-021 Drive RED_IN/GREEN_IN/BLUE_IN = F,A,5 constant -> VGA colour reads FA5 one tick after a visible pixel. Colour is 000 on every blanked pixel, including the first pixel after HBlank rises.
REQ-022 Assert RESET_N low at CurrentX=400, CurrentY=300 -> all outputs read 0 within the same CLK. After release, the counters restart at (0, 0).
REQ-023 With VGA_TEST_PAT_EN... correction: with VGA_TEST_PATTERN_EN defined and TEST_PAT=1 -> colour is 0F0 at CurrentX 200-299 and FFF at CurrentX 700-799. With TEST_PAT=0 -> colour equals the client inputs.
